taxi_i2c_target_regs: RTL and testbench

I2C target (slave) that is the responding end of the board-management I2C bus. It exposes a byte-wide register file of `2**REG_ADDR_W` entries to an external I2C controller using the standard pointer-then-data protocol. It is the in-fabric counterpart of the XFCP I2C master modules on the same bus style (`*_i`/`*_o` open-drain pairs), and is used for loopback verification of those masters and as a simple management-register target.

---
 rtl/taxi_i2c_target_regs.sv | 260 ++++++++++++++++++++++++++
 tb/tb_taxi_i2c_target_regs.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_i2c_target_regs.sv
// I2C target exposing a 2**REG_ADDR_W byte register file (pointer-then-data).
// Ports: clk/rst, i2c_{scl,sda}_{i,o} pins, dev_addr/enable config, reg_wr_* pulse, busy/addressed status.
module taxi_i2c_target_regs #(
  parameter int FILTER_LEN = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_scl_i,
  output logic                  i2c_scl_o,
  input  logic                  i2c_sda_i,
  output logic                  i2c_sda_o,
  input  logic [6:0]            dev_addr,
  input  logic                  enable,
  output logic                  reg_wr_en,
  output logic [REG_ADDR_W-1:0] reg_wr_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  busy,
  output logic                  addressed
);

  localparam int NREG = 2**REG_ADDR_W;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] CNT_MAX = FCW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK,
    S_WR_DATA,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  logic [1:0] scl_s_q, scl_s_d;
  logic [1:0] sda_s_q, sda_s_d;
  logic [FCW-1:0] scl_cnt_q, scl_cnt_d;
  logic [FCW-1:0] sda_cnt_q, sda_cnt_d;
  logic scl_f_q, scl_f_d;
  logic sda_f_q, sda_f_d;
  logic scl_p_q, sda_p_q;

  state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic first_q, first_d;
  logic rw_q, rw_d;
  logic sda_o_q, sda_o_d;
  logic wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic busy_q, busy_d;
  logic addressed_q, addressed_d;
  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];

  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rd_byte;

  assign i2c_scl_o   = 1'b1;
  assign i2c_sda_o   = sda_o_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign addressed   = addressed_q;

  assign rd_byte  = regs_q[ptr_q];
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_ev = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  // Level only flips after FILTER_LEN consecutive differing samples
  always_comb begin
    scl_s_d   = {scl_s_q[0], i2c_scl_i};
    sda_s_d   = {sda_s_q[0], i2c_sda_i};
    scl_cnt_d = scl_cnt_q;
    sda_cnt_d = sda_cnt_q;
    scl_f_d   = scl_f_q;
    sda_f_d   = sda_f_q;
    if (scl_s_q[1] == scl_f_q) begin
      scl_cnt_d = '0;
    end else if (scl_cnt_q == CNT_MAX) begin
      scl_cnt_d = '0;
      scl_f_d   = scl_s_q[1];
    end else begin
      scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_s_q[1] == sda_f_q) begin
      sda_cnt_d = '0;
    end else if (sda_cnt_q == CNT_MAX) begin
      sda_cnt_d = '0;
      sda_f_d   = sda_s_q[1];
    end else begin
      sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    rw_d        = rw_q;
    sda_o_d     = sda_o_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    if (start_ev) begin
      state_d     = S_ADDR;
      bit_cnt_d   = '0;
      addressed_d = 1'b0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b1;
    end else if (stop_ev) begin
      state_d     = S_IDLE;
      addressed_d = 1'b0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_WR_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == S_ADDR) begin
              if (enable && shift_q[7:1] == dev_addr) begin
                state_d     = S_ACK;
                sda_o_d     = 1'b0;
                addressed_d = 1'b1;
                rw_d        = shift_q[0];
                first_d     = 1'b1;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else begin
              state_d = S_ACK;
              sda_o_d = 1'b0;
              if (first_q) begin
                ptr_d   = shift_q[REG_ADDR_W-1:0];
                first_d = 1'b0;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_q;
                ptr_d     = ptr_q + 1'b1;
              end
            end
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              // first read bit goes out on the fall that ends the ACK
              state_d   = S_RD_DATA;
              sda_o_d   = rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d = S_WR_DATA;
              sda_o_d = 1'b1;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_o_d   = rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              state_d = S_RD_ACK;
              sda_o_d = 1'b1;
            end else begin
              sda_o_d   = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            // pointer advances past every byte sent, ACKed or not
            ptr_d = ptr_q + 1'b1;
            if (!sda_f_q) begin
              state_d   = S_RD_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en_d) regs_d[wr_addr_d] = wr_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s_q     <= 2'b11;
      sda_s_q     <= 2'b11;
      scl_cnt_q   <= '0;
      sda_cnt_q   <= '0;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      first_q     <= 1'b0;
      rw_q        <= 1'b0;
      sda_o_q     <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      scl_s_q     <= scl_s_d;
      sda_s_q     <= sda_s_d;
      scl_cnt_q   <= scl_cnt_d;
      sda_cnt_q   <= sda_cnt_d;
      scl_f_q     <= scl_f_d;
      sda_f_q     <= sda_f_d;
      scl_p_q     <= scl_f_q;
      sda_p_q     <= sda_f_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      rw_q        <= rw_d;
      sda_o_q     <= sda_o_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_taxi_i2c_target_regs.sv
// Testbench for taxi_i2c_target_regs: bus-master tasks drive directed
// transactions; a scoreboard monitor checks register writes and bus observations.
module tb_taxi_i2c_target_regs;

  localparam int Q = 15;
  localparam int T_ACK = 0;
  localparam int T_RD = 1;
  localparam int T_BUSY = 2;
  localparam int T_ADDRD = 3;
  localparam int T_SDA = 4;
  localparam int T_SCL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic i2c_scl_i, i2c_scl_o, i2c_sda_i, i2c_sda_o;
  logic [6:0] dev_addr = 7'h50;
  logic enable = 1'b1;
  logic reg_wr_en;
  logic [3:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic busy, addressed;

  always #83 clk = ~clk;

  assign i2c_scl_i = scl_m & i2c_scl_o;
  assign i2c_sda_i = sda_m & i2c_sda_o;

  taxi_i2c_target_regs #(.FILTER_LEN(4), .REG_ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .i2c_scl_i(i2c_scl_i),
    .i2c_scl_o(i2c_scl_o),
    .i2c_sda_i(i2c_sda_i),
    .i2c_sda_o(i2c_sda_o),
    .dev_addr(dev_addr),
    .enable(enable),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .busy(busy),
    .addressed(addressed)
  );

  typedef struct {
    int tag;
    logic [7:0] v;
  } item_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  item_t exp_q[$];
  item_t obs_q[$];
  wr_t exp_wr[$];
  int checks = 0;
  int errors = 0;

  function automatic string tname(int t);
    case (t)
      T_ACK:   return "ack";
      T_RD:    return "rd_byte";
      T_BUSY:  return "busy";
      T_ADDRD: return "addressed";
      T_SDA:   return "sda_o";
      T_SCL:   return "scl_o";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_item(input int t, input logic [7:0] v);
    item_t it;
    it.tag = t;
    it.v = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input int t, input logic [7:0] v);
    item_t it;
    it.tag = t;
    it.v = v;
    obs_q.push_back(it);
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    wr_t w;
    item_t o;
    item_t e;
    if (reg_wr_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr: unexpected write addr=%0d data=%02h",
                 reg_wr_addr, reg_wr_data);
      end else begin
        w = exp_wr.pop_front();
        if (reg_wr_addr !== w.a || reg_wr_data !== w.d) begin
          errors++;
          $display("FAIL wr: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   reg_wr_addr, reg_wr_data, w.a, w.d);
        end
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got %02h with no expectation", tname(o.tag), o.v);
      end else begin
        e = exp_q.pop_front();
        if (e.tag != o.tag || o.v !== e.v) begin
          errors++;
          $display("FAIL %s: got %02h expected %s=%02h",
                   tname(o.tag), o.v, tname(e.tag), e.v);
        end
      end
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
    wq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  // short SCL high pulse that the input filter must reject
  task automatic glitch();
    scl_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    scl_m = 1'b0;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                           input int glitch_at);
    expect_item(T_ACK, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i == glitch_at) glitch();
    end
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    observe(T_ACK, {7'd0, i2c_sda_i});
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic ack);
    logic [7:0] b;
    b = '0;
    expect_item(T_RD, exp_b);
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq();
      scl_m = 1'b1;
      wq();
      b = {b[6:0], i2c_sda_i};
      wq();
      scl_m = 1'b0;
      wq();
    end
    observe(T_RD, b);
    sda_m = ack;
    wq();
    scl_m = 1'b1;
    wq();
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic chk(input int t, input logic [7:0] exp_v, input logic [7:0] act);
    expect_item(t, exp_v);
    observe(t, act);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk(T_SDA, 8'h01, {7'd0, i2c_sda_o});
    chk(T_SCL, 8'h01, {7'd0, i2c_scl_o});
    chk(T_BUSY, 8'h00, {7'd0, busy});
    chk(T_ADDRD, 8'h00, {7'd0, addressed});

    // write 0x11, 0x22 from pointer 3
    i2c_start();
    chk(T_BUSY, 8'h01, {7'd0, busy});
    send_byte(8'hA0, 1'b0, -1);
    chk(T_ADDRD, 8'h01, {7'd0, addressed});
    send_byte(8'h03, 1'b0, -1);
    expect_wr(4'd3, 8'h11);
    send_byte(8'h11, 1'b0, -1);
    expect_wr(4'd4, 8'h22);
    send_byte(8'h22, 1'b0, -1);
    i2c_stop();
    chk(T_ADDRD, 8'h00, {7'd0, addressed});
    chk(T_BUSY, 8'h00, {7'd0, busy});

    // random read from pointer 3
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h03, 1'b0, -1);
    i2c_start();
    chk(T_ADDRD, 8'h00, {7'd0, addressed});
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h11, 1'b0);
    recv_byte(8'h22, 1'b1);
    i2c_stop();

    // address mismatch, then disabled target
    i2c_start();
    send_byte(8'hA2, 1'b1, -1);
    chk(T_ADDRD, 8'h00, {7'd0, addressed});
    send_byte(8'h55, 1'b1, -1);
    chk(T_BUSY, 8'h01, {7'd0, busy});
    i2c_stop();
    chk(T_BUSY, 8'h00, {7'd0, busy});
    enable = 1'b0;
    i2c_start();
    send_byte(8'hA0, 1'b1, -1);
    send_byte(8'h55, 1'b1, -1);
    i2c_stop();
    enable = 1'b1;

    // pointer wrap
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h0F, 1'b0, -1);
    expect_wr(4'd15, 8'hAA);
    send_byte(8'hAA, 1'b0, -1);
    expect_wr(4'd0, 8'hBB);
    send_byte(8'hBB, 1'b0, -1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h0F, 1'b0, -1);
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'hAA, 1'b0);
    recv_byte(8'hBB, 1'b1);
    i2c_stop();

    // glitch mid-byte, then aborted partial byte
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h07, 1'b0, -1);
    expect_wr(4'd7, 8'h3C);
    send_byte(8'h3C, 1'b0, -1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h06, 1'b0, -1);
    expect_wr(4'd6, 8'h5A);
    send_byte(8'h5A, 1'b0, 4);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h3C, 1'b1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h06, 1'b0, -1);
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h5A, 1'b1);
    i2c_stop();

    // reset while the target drives bit 7 (0) of 0x11
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h03, 1'b0, -1);
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    chk(T_SDA, 8'h00, {7'd0, i2c_sda_o});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(T_SDA, 8'h01, {7'd0, i2c_sda_o});
    chk(T_BUSY, 8'h00, {7'd0, busy});
    chk(T_ADDRD, 8'h00, {7'd0, addressed});
    rst = 1'b0;
    sda_m = 1'b1;
    wq();
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h00, 1'b1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h03, 1'b0, -1);
    i2c_start();
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h00, 1'b1);
    i2c_stop();

    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL wr_drain: %0d writes missing, required 0", exp_wr.size());
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL bus_drain: %0d expected / %0d observed left, required 0/0",
               exp_q.size(), obs_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL timeout: run exceeded 90000 cycles, required completion");
    $fatal(1, "timeout");
  end

endmodule
